// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - shared state encoding and default widths for the RAM arbiter
package ram_ctrl_pkg;

  localparam int DEF_ADDRESS_SIZE = 20;
  localparam int DEF_DATA_WIDTH   = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-way round-robin pick producing a one-hot grant
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       pointer,
  output logic [1:0] grant
);

  // pointer=0 favours requester 0, pointer=1 favours requester 1
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = pointer ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_arbiter_2p.sv
// rtl/ram_arbiter_2p.sv - two-requester single-port RAM arbiter, one transaction per three cycles
module ram_arbiter_2p
  import ram_ctrl_pkg::*;
#(
  parameter int ADDRESS_SIZE = DEF_ADDRESS_SIZE,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_we,
  input  logic [ADDRESS_SIZE-1:0] req_addr0,
  input  logic [ADDRESS_SIZE-1:0] req_addr1,
  input  logic [DATA_WIDTH-1:0]   req_wdata0,
  input  logic [DATA_WIDTH-1:0]   req_wdata1,
  output logic [1:0]              req_ready,
  output logic [1:0]              resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic [ADDRESS_SIZE-1:0] ram_addressBus,
  output logic [DATA_WIDTH-1:0]   ram_dataBus_IN,
  input  logic [DATA_WIDTH-1:0]   ram_dataBus_OUT,
  output logic                    ram_RDwr
);

  state_t                  state;
  logic                    pointer;
  logic [1:0]              grant;
  logic [1:0]              grantReg;
  logic                    capWe;
  logic [ADDRESS_SIZE-1:0] capAddr;
  logic [DATA_WIDTH-1:0]   capWdata;

  rr_arbiter_2 u_rr (
    .req     (req_valid),
    .pointer (pointer),
    .grant   (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pointer    <= 1'b0;
      grantReg   <= 2'b00;
      capWe      <= 1'b0;
      capAddr    <= '0;
      capWdata   <= '0;
      resp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            state    <= ACCESS;
            grantReg <= grant;
            // the loser of this round is favoured next time
            pointer  <= grant[0];
            capWe    <= grant[1] ? req_we[1]  : req_we[0];
            capAddr  <= grant[1] ? req_addr1  : req_addr0;
            capWdata <= grant[1] ? req_wdata1 : req_wdata0;
          end
        end
        ACCESS: begin
          state <= RESP;
          if (!capWe) begin
            resp_rdata <= ram_dataBus_OUT;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // the RAM bus is parked in read mode with zeroes outside ACCESS, so reset quiets it at once
  always_comb begin
    req_ready      = (state == IDLE && !rst) ? grant : 2'b00;
    resp_valid     = (state == RESP) ? grantReg : 2'b00;
    ram_addressBus = (state == ACCESS) ? capAddr : '0;
    ram_dataBus_IN = (state == ACCESS) ? capWdata : '0;
    ram_RDwr       = (state == ACCESS) ? !capWe : 1'b1;
  end

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// tb/tb_ram_arbiter_2p.sv - self-checking bench for ram_arbiter_2p with RAM model and scoreboard
module tb_ram_arbiter_2p;

  localparam int AW = 20;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid;
  logic [1:0]    req_we;
  logic [AW-1:0] req_addr0, req_addr1;
  logic [DW-1:0] req_wdata0, req_wdata1;
  logic [1:0]    req_ready, resp_valid;
  logic [DW-1:0] resp_rdata;
  logic [AW-1:0] ram_addressBus;
  logic [DW-1:0] ram_dataBus_IN, ram_dataBus_OUT;
  logic          ram_RDwr;

  always #5 clk = ~clk;

  ram_arbiter_2p #(.ADDRESS_SIZE(AW), .DATA_WIDTH(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_we          (req_we),
    .req_addr0       (req_addr0),
    .req_addr1       (req_addr1),
    .req_wdata0      (req_wdata0),
    .req_wdata1      (req_wdata1),
    .req_ready       (req_ready),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .ram_addressBus  (ram_addressBus),
    .ram_dataBus_IN  (ram_dataBus_IN),
    .ram_dataBus_OUT (ram_dataBus_OUT),
    .ram_RDwr        (ram_RDwr)
  );

  // RAM model: combinational read, write on the edge while ram_RDwr is low
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          preWe;
  logic [AW-1:0] preAddr;
  logic [DW-1:0] preData;
  int            wrCycles = 0;

  assign ram_dataBus_OUT = mem[ram_addressBus];

  always @(posedge clk) begin
    if (preWe) mem[preAddr] <= preData;
    else if (!ram_RDwr) mem[ram_addressBus] <= ram_dataBus_IN;
    if (!ram_RDwr) wrCycles++;
  end

  int vecs = 0;
  int miscompares = 0;

  typedef struct {
    logic [1:0]    id1h;
    logic [DW-1:0] rdata;
  } sb_t;
  sb_t sbq[$];
  sb_t sbe;

  typedef struct {
    logic          id;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] expRdata;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (resp_valid != 2'b00) begin
      if (sbq.size() == 0) begin
        vecs++;
        miscompares++;
        $display("FAIL unexpected_resp: got resp_valid=%b, expected none", resp_valid);
      end else begin
        sbe = sbq.pop_front();
        check("resp_valid", 64'(resp_valid), 64'(sbe.id1h));
        check("resp_rdata", 64'(resp_rdata), 64'(sbe.rdata));
      end
    end
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    preWe = 1'b1; preAddr = a; preData = d;
    @(posedge clk); #1;
    preWe = 1'b0;
  endtask

  task automatic setReq(input logic id, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (id) begin req_we[1] = we; req_addr1 = a; req_wdata1 = d; end
    else    begin req_we[0] = we; req_addr0 = a; req_wdata0 = d; end
    req_valid[id] = 1'b1;
  endtask

  task automatic waitReady(output bit ok);
    int w = 0;
    while (req_ready == 2'b00 && w < 20) begin @(negedge clk); #1; w++; end
    ok = (req_ready != 2'b00);
    if (!ok) begin
      vecs++; miscompares++;
      $display("FAIL ready_timeout: got req_ready=%b, expected a grant", req_ready);
    end
  endtask

  task automatic doTxn(input vec_t v);
    bit ok;
    int w0;
    logic [1:0] oh;
    oh = 2'b01 << v.id;
    @(negedge clk);
    setReq(v.id, v.we, v.addr, v.wdata);
    #1;
    waitReady(ok);
    if (!ok) begin req_valid = 2'b00; return; end
    check("req_ready", 64'(req_ready), 64'(oh));
    sbq.push_back('{oh, v.expRdata});
    w0 = wrCycles;
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk); #1;
    check("access_addr", 64'(ram_addressBus), 64'(v.addr));
    check("access_rdwr", 64'(ram_RDwr), 64'(!v.we));
    check("access_ready_low", 64'(req_ready), 64'(0));
    if (v.we) check("access_wdata", 64'(ram_dataBus_IN), 64'(v.wdata));
    @(negedge clk); #1;
    check("resp_rdwr", 64'(ram_RDwr), 64'(1));
    @(negedge clk); #1;
    if (v.we) check("write_cycles", 64'(wrCycles - w0), 64'(1));
  endtask

  task automatic resetDut();
    rst = 1'b1;
    sbq.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bit ok;
    int cyc, lastCyc, badRd, w0;
    logic [1:0] expG;

    rst = 1'b1; preWe = 1'b0; preAddr = '0; preData = '0;
    req_valid = 2'b11; req_we = 2'b00;
    req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;

    tbl[0] = '{1'b0, 1'b0, 20'h00005, 32'h0,        32'hDEADBEEF};
    tbl[1] = '{1'b1, 1'b1, 20'hFFFFF, 32'h12345678, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 1'b0, 20'hFFFFF, 32'h0,        32'h12345678};
    tbl[3] = '{1'b0, 1'b1, 20'h00000, 32'hA5A5A5A5, 32'h12345678};
    tbl[4] = '{1'b0, 1'b0, 20'h00000, 32'h0,        32'hA5A5A5A5};
    tbl[5] = '{1'b1, 1'b0, 20'h00005, 32'h0,        32'hDEADBEEF};
    tbl[6] = '{1'b1, 1'b1, 20'h00010, 32'h00000000, 32'hDEADBEEF};
    tbl[7] = '{1'b0, 1'b0, 20'h00010, 32'h0,        32'h00000000};

    preload(20'h00005, 32'hDEADBEEF);
    preload(20'h00020, 32'h0BADF00D);
    preload(20'h00010, 32'h77777777);
    preload(20'hFFFFF, 32'h00000000);
    preload(20'h00000, 32'h00000000);

    // reset values, with both requests asserted to show ready stays low
    @(negedge clk); #1;
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_rdata", 64'(resp_rdata), 64'(0));
    check("rst_rdwr", 64'(ram_RDwr), 64'(1));
    check("rst_addr", 64'(ram_addressBus), 64'(0));
    check("rst_din", 64'(ram_dataBus_IN), 64'(0));
    req_valid = 2'b00;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) doTxn(tbl[i]);

    // simultaneous continuous requests after reset: strict alternation, three cycles apart
    resetDut();
    @(negedge clk);
    setReq(1'b0, 1'b0, 20'h00005, 32'h0);
    setReq(1'b1, 1'b0, 20'hFFFFF, 32'h0);
    #1;
    cyc = 0; lastCyc = 0;
    for (int g = 0; g < 6; g++) begin
      int w = 0;
      while (req_ready == 2'b00 && w < 10) begin @(negedge clk); #1; cyc++; w++; end
      expG = (g % 2 == 0) ? 2'b01 : 2'b10;
      check("alt_grant", 64'(req_ready), 64'(expG));
      if (g > 0) check("alt_spacing", 64'(cyc - lastCyc), 64'(3));
      lastCyc = cyc;
      sbq.push_back('{expG, (g % 2 == 0) ? 32'hDEADBEEF : 32'h12345678});
      @(negedge clk); #1; cyc++;
    end
    req_valid = 2'b00;
    repeat (3) @(negedge clk);

    // reset mid-ACCESS of a requester-0 write, with the pointer favouring requester 1
    @(negedge clk);
    setReq(1'b0, 1'b1, 20'h00020, 32'h55555555);
    #1;
    waitReady(ok);
    @(posedge clk); #1;
    check("mid_access_rdwr", 64'(ram_RDwr), 64'(0));
    rst = 1'b1;
    req_valid = 2'b00;
    #1;
    check("midrst_rdwr", 64'(ram_RDwr), 64'(1));
    check("midrst_addr", 64'(ram_addressBus), 64'(0));
    check("midrst_din", 64'(ram_dataBus_IN), 64'(0));
    check("midrst_ready", 64'(req_ready), 64'(0));
    check("midrst_resp_valid", 64'(resp_valid), 64'(0));
    check("midrst_rdata", 64'(resp_rdata), 64'(0));
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_no_write", 64'(mem[20'h00020]), 64'(32'h0BADF00D));
    setReq(1'b0, 1'b0, 20'h00005, 32'h0);
    setReq(1'b1, 1'b0, 20'h00020, 32'h0);
    #1;
    waitReady(ok);
    check("post_rst_grant", 64'(req_ready), 64'(2'b01));
    sbq.push_back('{2'b01, 32'hDEADBEEF});
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (3) @(negedge clk);

    // idle safety
    w0 = wrCycles; badRd = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); #1;
      if (ram_RDwr !== 1'b1) badRd++;
    end
    check("idle_rdwr_low_cycles", 64'(badRd), 64'(0));
    check("idle_write_cycles", 64'(wrCycles - w0), 64'(0));
    check("idle_mem5", 64'(mem[20'h00005]), 64'(32'hDEADBEEF));
    check("idle_memfffff", 64'(mem[20'hFFFFF]), 64'(32'h12345678));
    check("sb_drained", 64'(sbq.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
